riscv_hwloop_controller_seq: RTL and testbench

// - Consumer side of the two-set hardware-loop register file. It watches the issuing PC and

---
 rtl/riscv_hwloop_controller_seq_if.sv | 23 ++
 rtl/riscv_hwloop_controller_seq.sv | 114 +++++++++++
 tb/tb_riscv_hwloop_controller_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/riscv_hwloop_controller_seq_if.sv
// Issue-side and fetch-side handshake bundle for the hardware-loop controller.
// The master side is the core (issue PC, fetch ack); the slave side is the controller.
interface riscv_hwloop_controller_seq_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_i;
  logic              pc_valid_i;
  logic              pc_ready_o;
  logic              hwlp_jump_o;
  logic [ADDR_W-1:0] hwlp_target_o;
  logic              hwlp_jump_ack_i;
  logic [1:0]        hwlp_dec_cnt_o;

  modport master (
    output pc_i, pc_valid_i, hwlp_jump_ack_i,
    input  pc_ready_o, hwlp_jump_o, hwlp_target_o, hwlp_dec_cnt_o
  );

  modport slave (
    input  pc_i, pc_valid_i, hwlp_jump_ack_i,
    output pc_ready_o, hwlp_jump_o, hwlp_target_o, hwlp_dec_cnt_o
  );
endinterface

// File: rtl/riscv_hwloop_controller_seq.sv
// Two-set hardware-loop consumer: matches issuing PC against loop end addresses,
// pulses counter decrements and holds a jump-to-start request until fetch acks or a flush.
module riscv_hwloop_controller_seq #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  riscv_hwloop_controller_seq_if.slave bus,
  input  logic [ADDR_W-1:0] hwlp_start_addr_0_i,
  input  logic [ADDR_W-1:0] hwlp_end_addr_0_i,
  input  logic [CNT_W-1:0]  hwlp_counter_0_i,
  input  logic [ADDR_W-1:0] hwlp_start_addr_1_i,
  input  logic [ADDR_W-1:0] hwlp_end_addr_1_i,
  input  logic [CNT_W-1:0]  hwlp_counter_1_i,
  input  logic              hwlp_flush_i
);

  typedef enum logic {
    IDLE,
    JUMP_PEND
  } state_e;

  state_e            state_q, state_d;
  logic              jump_q, jump_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [1:0]        dec_q, dec_d;
  logic              ready_q, ready_d;

  logic              match_0, match_1;
  logic              accept;
  logic [1:0]        hit_dec;
  logic              hit_jump;
  logic [ADDR_W-1:0] hit_tgt;

  // A zero counter marks an inactive loop, so it can never match or decrement.
  assign match_0 = (hwlp_counter_0_i != '0) && (bus.pc_i == hwlp_end_addr_0_i);
  assign match_1 = (hwlp_counter_1_i != '0) && (bus.pc_i == hwlp_end_addr_1_i);
  assign accept  = bus.pc_valid_i && ready_q;

  // Inner loop has priority; only its final iteration lets the outer loop see the same end address.
  always_comb begin
    hit_dec  = '0;
    hit_jump = 1'b0;
    hit_tgt  = '0;
    if (match_0) begin
      hit_dec[0] = 1'b1;
      if (hwlp_counter_0_i > CNT_W'(1)) begin
        hit_jump = 1'b1;
        hit_tgt  = hwlp_start_addr_0_i;
      end else if (match_1) begin
        hit_dec[1] = 1'b1;
        if (hwlp_counter_1_i > CNT_W'(1)) begin
          hit_jump = 1'b1;
          hit_tgt  = hwlp_start_addr_1_i;
        end
      end
    end else if (match_1) begin
      hit_dec[1] = 1'b1;
      if (hwlp_counter_1_i > CNT_W'(1)) begin
        hit_jump = 1'b1;
        hit_tgt  = hwlp_start_addr_1_i;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dec_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dec_d = hit_dec;
          // A flush in the accept cycle keeps the decrement but cancels the jump.
          if (hit_jump && !hwlp_flush_i) begin
            state_d  = JUMP_PEND;
            target_d = hit_tgt;
          end
        end
      end
      JUMP_PEND: begin
        if (hwlp_flush_i || bus.hwlp_jump_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    jump_d  = (state_d == JUMP_PEND);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      jump_q   <= 1'b0;
      target_q <= '0;
      dec_q    <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      jump_q   <= jump_d;
      target_q <= target_d;
      dec_q    <= dec_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.pc_ready_o     = ready_q;
  assign bus.hwlp_jump_o    = jump_q;
  assign bus.hwlp_target_o  = target_q;
  assign bus.hwlp_dec_cnt_o = dec_q;

endmodule

// File: tb/tb_riscv_hwloop_controller_seq.sv
// Directed bench for the hardware-loop controller with hand-computed expectations.
module tb_riscv_hwloop_controller_seq;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;

  logic clk;
  logic rst;
  logic [ADDR_W-1:0] start0, end0, start1, end1;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic              flush;

  int unsigned checks_cnt;
  int unsigned errors_cnt;

  riscv_hwloop_controller_seq_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_hwloop_controller_seq #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .hwlp_start_addr_0_i(start0),
    .hwlp_end_addr_0_i  (end0),
    .hwlp_counter_0_i   (cnt0),
    .hwlp_start_addr_1_i(start1),
    .hwlp_end_addr_1_i  (end1),
    .hwlp_counter_1_i   (cnt1),
    .hwlp_flush_i       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] dec, input logic jump,
                           input logic [31:0] tgt, input logic ready);
    check({tag, ".dec"},   32'(bus.hwlp_dec_cnt_o), 32'(dec));
    check({tag, ".jump"},  32'(bus.hwlp_jump_o),    32'(jump));
    check({tag, ".tgt"},   bus.hwlp_target_o,       tgt);
    check({tag, ".ready"}, 32'(bus.pc_ready_o),     32'(ready));
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1; flush = 1'b0;
    start0 = '0; end0 = '0; cnt0 = '0;
    start1 = '0; end1 = '0; cnt1 = '0;
    bus.pc_i = '0; bus.pc_valid_i = 1'b0; bus.hwlp_jump_ack_i = 1'b0;
    step();
    step();
    check_out("reset", 2'b00, 1'b0, 32'h0, 1'b1);
    rst = 1'b0;

    // Basic jump with ack in the first pending cycle
    end0 = 32'h100; start0 = 32'h80; cnt0 = 3;
    bus.pc_i = 32'h100; bus.pc_valid_i = 1'b1;
    step();
    check_out("jump0", 2'b01, 1'b1, 32'h80, 1'b0);
    bus.pc_valid_i = 1'b0; bus.hwlp_jump_ack_i = 1'b1;
    step();
    check_out("ack0", 2'b00, 1'b0, 32'h80, 1'b1);
    bus.hwlp_jump_ack_i = 1'b0;

    // Last iteration: decrement only
    cnt0 = 1; bus.pc_valid_i = 1'b1;
    step();
    check_out("exit0", 2'b01, 1'b0, 32'h80, 1'b1);
    bus.pc_valid_i = 1'b0;
    step();
    check_out("exit0_after", 2'b00, 1'b0, 32'h80, 1'b1);

    // Nested loops sharing an end address
    end0 = 32'h200; end1 = 32'h200; cnt0 = 1; cnt1 = 5; start1 = 32'h40;
    bus.pc_i = 32'h200; bus.pc_valid_i = 1'b1;
    step();
    check_out("nested", 2'b11, 1'b1, 32'h40, 1'b0);
    bus.pc_valid_i = 1'b0; bus.hwlp_jump_ack_i = 1'b1;
    step();
    check_out("nested_ack", 2'b00, 1'b0, 32'h40, 1'b1);
    bus.hwlp_jump_ack_i = 1'b0;

    // Inner loop still iterating: outer loop must not be evaluated
    cnt0 = 2; bus.pc_valid_i = 1'b1; start0 = 32'h180;
    step();
    check_out("inner_only", 2'b01, 1'b1, 32'h180, 1'b0);
    bus.pc_valid_i = 1'b0; bus.hwlp_jump_ack_i = 1'b1;
    step();
    bus.hwlp_jump_ack_i = 1'b0;

    // Outer loop alone, final iteration
    end0 = 32'h300; cnt0 = 2; cnt1 = 1;
    bus.pc_valid_i = 1'b1;
    step();
    check_out("outer_exit", 2'b10, 1'b0, 32'h180, 1'b1);

    // No match
    bus.pc_i = 32'h204;
    step();
    check_out("nomatch", 2'b00, 1'b0, 32'h180, 1'b1);

    // Ack withheld 4 cycles; valid stays high and regfile changes must be ignored
    end0 = 32'h100; start0 = 32'h80; cnt0 = 3; cnt1 = 0;
    bus.pc_i = 32'h100; bus.pc_valid_i = 1'b1;
    step();
    check_out("hold_c1", 2'b01, 1'b1, 32'h80, 1'b0);
    start0 = 32'h999; cnt0 = 7;
    for (int i = 2; i <= 4; i++) begin
      step();
      check_out($sformatf("hold_c%0d", i), 2'b00, 1'b1, 32'h80, 1'b0);
    end
    bus.pc_valid_i = 1'b0; bus.hwlp_jump_ack_i = 1'b1;
    step();
    check_out("hold_ack", 2'b00, 1'b0, 32'h80, 1'b1);
    bus.hwlp_jump_ack_i = 1'b0;
    start0 = 32'h80; cnt0 = 3;

    // Flush in the second pending cycle
    bus.pc_valid_i = 1'b1;
    step();
    check_out("fl_c1", 2'b01, 1'b1, 32'h80, 1'b0);
    bus.pc_valid_i = 1'b0;
    step();
    check_out("fl_c2", 2'b00, 1'b1, 32'h80, 1'b0);
    flush = 1'b1;
    step();
    check_out("fl_done", 2'b00, 1'b0, 32'h80, 1'b1);
    flush = 1'b0;

    // Inactive loop never matches
    cnt0 = 0; bus.pc_valid_i = 1'b1;
    step();
    check_out("cnt_zero", 2'b00, 1'b0, 32'h80, 1'b1);

    // Flush in the accept cycle: decrement kept, jump suppressed
    cnt0 = 3; start0 = 32'h88; flush = 1'b1;
    step();
    check_out("fl_accept", 2'b01, 1'b0, 32'h80, 1'b1);
    flush = 1'b0; bus.pc_valid_i = 1'b0;
    step();
    check_out("fl_accept_after", 2'b00, 1'b0, 32'h80, 1'b1);

    // Reset while pending
    bus.pc_valid_i = 1'b1;
    step();
    check_out("rst_pend", 2'b01, 1'b1, 32'h88, 1'b0);
    bus.pc_valid_i = 1'b0; rst = 1'b1;
    step();
    check_out("rst_mid", 2'b00, 1'b0, 32'h0, 1'b1);
    rst = 1'b0;
    step();
    check_out("rst_after", 2'b00, 1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
